seq_num_alloc: RTL and testbench
================================

Name: seq_num_alloc

Overview:
- Issue-side counterpart of the writeback-commit unit.
- Hands out sequence numbers to instructions entering the execute pipes.
- Tracks which numbers are in flight and records completions from CompleteNotif.
- Frees numbers in order as CommitNotif retires them; supports squash rollback. Sits between decode/issue and the X pipes.

Parameters:
- p_seq_num_bits, 3, width of sequence numbers; in-flight capacity is 2^p_seq_num_bits.

Ports:
- clk  in  1  clock
- rst  in  1  reset; asynchronous, active-low
- alloc_val  in  1  issue requests a sequence number
- alloc_rdy  out  1  a number is available
- alloc_seq_num  out  p_seq_num_bits  number granted when alloc_val & alloc_rdy
- complete_val  in  1  CompleteNotif valid
- complete_seq_num  in  p_seq_num_bits  completed number
- commit_val  in  1  CommitNotif valid
- commit_seq_num  in  p_seq_num_bits  committed number
- squash_val  in  1  squash request
- squash_seq_num  in  p_seq_num_bits  youngest surviving number
- oldest_seq_num  out  p_seq_num_bits  oldest in-flight number (tail)
- oldest_complete  out  1  oldest in-flight number has completed
- in_flight  out  p_seq_num_bits+1  count of in-flight numbers
- empty  out  1  in_flight == 0
- err  out  1  sticky protocol-violation flag

Behaviour:
State:
- head: next number to grant.
- tail: oldest in-flight number.
- count: p_seq_num_bits+1 bits.
- done[2^N]: completion bits.

Reset (rst low, asynchronous):
- head=tail=0, count=0, done=0, err=0.
- alloc_rdy=0 while rst is low, then 1 after release.

In-flight test for s: ((s - tail) mod 2^N) < count.

Outputs (all from registered state):
- alloc_seq_num = head.
- alloc_rdy = (count != 2^N) & !squash_val. No combinational path from commit_val to alloc_rdy.
- oldest_seq_num = tail.
- oldest_complete = (count != 0) & done[tail].
- empty = (count == 0).

Allocate (alloc_val & alloc_rdy):
- head <= head+1, wrapping mod 2^N.
- done[head] <= 0.
- count +1.

Complete (complete_val):
- If complete_seq_num is in flight, done[s] <= 1.
- Otherwise err <= 1 and nothing else changes.

Commit (commit_val):
- Legal only if count != 0 and commit_seq_num == tail.
- Legal commit: tail+1, done[tail] <= 0, count -1.
- Illegal commit: err <= 1, no state change.

Squash (squash_val):
- squash_seq_num must be in flight; otherwise err <= 1 and the squash is ignored.
- head <= squash_seq_num+1.
- count <= ((squash_seq_num - tail) mod 2^N) + 1.
- Allocation is blocked that cycle.

Simultaneous events:
- Commit + allocate in the same cycle: count unchanged. At full, alloc_rdy stays 0 that cycle and rises the next cycle.
- Commit + squash in the same cycle: both apply. count = squash result - 1. If squash_seq_num == tail, count = 0 and head = tail+1 = new tail.
- Complete + commit of the same number in the same cycle: the commit wins; done is cleared.
- Complete for a number allocated in the same cycle: checked against pre-update state, so it sets err.

Other rules:
- Latency: a grant is visible combinationally; all updates take effect at the next posedge.
- err stays set until reset.
- Reset mid-operation discards all in-flight state immediately.

Decomposition:
- Shared package gains:
  - a seq-num type parameterised by width;
  - a function seq_age(s, tail) returning (s - tail) mod 2^N;
  - a function seq_in_flight(s, tail, count).
- These helpers are reused by the writeback-commit unit.
- One sub-module: seq_done_table, the 2^N completion-bit array with set/clear/read ports and async active-low reset.
- Module provides trace() in the team's linetrace format.

Test Plan (p_seq_num_bits=3):
- Reset, then alloc_val held for 8 cycles -> grants 0..7; alloc_rdy=0 and in_flight=8 afterward; a 9th request stalls.
- At full, commit 0 with alloc_val=1 -> no grant that cycle; next cycle grant 0, in_flight=8, oldest_seq_num=1.
- Allocate 0..2, complete 2 then 0 -> oldest_complete=1 only after 0 completes. Commit 0 -> oldest_complete=0 (1 not done). Complete 1 -> 1; commit 1, commit 2 -> empty=1.
- Allocate 0..5, squash 2 -> in_flight=3, next grant 3. Then squash 0 together with commit 0 -> empty=1, next grant 1.
- Protocol errors:
  - commit 1 while oldest is 0 -> err=1, in_flight unchanged;
  - complete 6 when 0..2 are in flight -> err stays 1;
  - assert rst low mid-stream -> err=0, in_flight=0, next grant 0.
- 20 back-to-back alloc/commit pairs -> grants cycle 0..7,0..7,0..3 (wrap-around); err=0 throughout.

Source files
------------

// File: rtl/seq_num_alloc_pkg.sv
// seq_num_alloc_pkg
//   Shared sequence-number helpers for the issue-side allocator and the
//   writeback-commit unit.
//   seq_wide_t    : container wide enough for any sequence-number width in use;
//                   callers zero-extend their narrow numbers into it.
//   seq_age       : distance of s from tail, modulo 2^bits.
//   seq_in_flight : s lies inside the window [tail, tail+count).
package seq_num_alloc_pkg;

  localparam int unsigned SEQ_MAX_BITS = 16;

  typedef logic [SEQ_MAX_BITS-1:0] seq_wide_t;

  function automatic seq_wide_t seq_age(input seq_wide_t s,
                                        input seq_wide_t tail,
                                        input int unsigned bits);
    seq_wide_t mask;
    mask = (seq_wide_t'(1) << bits) - seq_wide_t'(1);
    return (s - tail) & mask;
  endfunction

  function automatic logic seq_in_flight(input seq_wide_t s,
                                         input seq_wide_t tail,
                                         input seq_wide_t count,
                                         input int unsigned bits);
    return seq_age(s, tail, bits) < count;
  endfunction

endpackage

// File: rtl/seq_done_table.sv
// seq_done_table
//   One completion bit per sequence number.
//   clk, rst        : clock, asynchronous active-low reset (clears all bits)
//   set_en/set_idx  : mark a number complete
//   clr_a_en/idx    : clear a bit (used on allocation)
//   clr_b_en/idx    : clear a bit (used on commit)
//   rd_idx/rd_done  : combinational read of one bit
//   A clear and a set of the same bit in one cycle leaves it cleared.
module seq_done_table #(
  parameter int unsigned p_idx_bits = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  set_en,
  input  logic [p_idx_bits-1:0] set_idx,
  input  logic                  clr_a_en,
  input  logic [p_idx_bits-1:0] clr_a_idx,
  input  logic                  clr_b_en,
  input  logic [p_idx_bits-1:0] clr_b_idx,
  input  logic [p_idx_bits-1:0] rd_idx,
  output logic                  rd_done
);

  localparam int unsigned DEPTH = 1 << p_idx_bits;

  typedef logic [DEPTH-1:0] vec_t;

  vec_t done_q;
  vec_t set_mask;
  vec_t clr_mask;

  always_comb begin
    set_mask = vec_t'(set_en) << set_idx;
    clr_mask = (vec_t'(clr_a_en) << clr_a_idx) | (vec_t'(clr_b_en) << clr_b_idx);
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      done_q <= '0;
    end else begin
      done_q <= (done_q | set_mask) & ~clr_mask;
    end
  end

  assign rd_done = done_q[rd_idx];

endmodule

// File: rtl/seq_num_alloc.sv
// seq_num_alloc
//   Hands out sequence numbers in order to instructions entering the execute
//   pipes, tracks completions, retires numbers in order on commit and rolls
//   the window back on squash.
//   clk, rst                       : clock, asynchronous active-low reset
//   alloc_val/alloc_rdy            : allocation handshake
//   alloc_seq_num                  : number granted on alloc_val & alloc_rdy
//   complete_val/complete_seq_num  : completion notification
//   commit_val/commit_seq_num      : in-order commit notification
//   squash_val/squash_seq_num      : squash; squash_seq_num is youngest survivor
//   oldest_seq_num/oldest_complete : tail of the window and its done bit
//   in_flight, empty               : occupancy
//   err                            : sticky protocol-violation flag
module seq_num_alloc
  import seq_num_alloc_pkg::*;
#(
  parameter int unsigned p_seq_num_bits = 3
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic                      alloc_val,
  output logic                      alloc_rdy,
  output logic [p_seq_num_bits-1:0] alloc_seq_num,
  input  logic                      complete_val,
  input  logic [p_seq_num_bits-1:0] complete_seq_num,
  input  logic                      commit_val,
  input  logic [p_seq_num_bits-1:0] commit_seq_num,
  input  logic                      squash_val,
  input  logic [p_seq_num_bits-1:0] squash_seq_num,
  output logic [p_seq_num_bits-1:0] oldest_seq_num,
  output logic                      oldest_complete,
  output logic [p_seq_num_bits:0]   in_flight,
  output logic                      empty,
  output logic                      err
);

  localparam int unsigned DEPTH = 1 << p_seq_num_bits;

  typedef logic [p_seq_num_bits-1:0] seq_t;
  typedef logic [p_seq_num_bits:0]   cnt_t;

  localparam cnt_t CNT_FULL = cnt_t'(DEPTH);

  seq_t head_q, head_d;
  seq_t tail_q, tail_d;
  cnt_t count_q, count_d;
  logic err_q, err_d;

  seq_t squash_age;
  logic alloc_fire;
  logic complete_ok;
  logic commit_ok;
  logic squash_ok;
  logic tail_done;

  always_comb begin
    // Depends only on registered state, squash_val and reset: commit_val
    // never reaches alloc_rdy, so a commit at full frees a slot next cycle.
    alloc_rdy   = rst && (count_q != CNT_FULL) && !squash_val;
    alloc_fire  = alloc_val && alloc_rdy;

    // All legality checks see the pre-update window.
    complete_ok = seq_in_flight(seq_wide_t'(complete_seq_num), seq_wide_t'(tail_q),
                                seq_wide_t'(count_q), p_seq_num_bits);
    squash_ok   = seq_in_flight(seq_wide_t'(squash_seq_num), seq_wide_t'(tail_q),
                                seq_wide_t'(count_q), p_seq_num_bits);
    commit_ok   = commit_val && (count_q != '0) && (commit_seq_num == tail_q);
    squash_age  = seq_t'(seq_age(seq_wide_t'(squash_seq_num), seq_wide_t'(tail_q),
                                 p_seq_num_bits));

    err_d = err_q
          | (complete_val && !complete_ok)
          | (commit_val   && !commit_ok)
          | (squash_val   && !squash_ok);

    tail_d = commit_ok ? tail_q + seq_t'(1) : tail_q;

    // Squash rebuilds the window length from its own age; a same-cycle
    // commit then removes the tail. Allocation cannot fire while squashing.
    if (squash_val && squash_ok) begin
      head_d  = squash_seq_num + seq_t'(1);
      count_d = cnt_t'(squash_age) + cnt_t'(1) - cnt_t'(commit_ok);
    end else begin
      head_d  = head_q + seq_t'(alloc_fire);
      count_d = count_q + cnt_t'(alloc_fire) - cnt_t'(commit_ok);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      err_q   <= 1'b0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      err_q   <= err_d;
    end
  end

  seq_done_table #(
    .p_idx_bits (p_seq_num_bits)
  ) u_done (
    .clk       (clk),
    .rst       (rst),
    .set_en    (complete_val && complete_ok),
    .set_idx   (complete_seq_num),
    .clr_a_en  (alloc_fire),
    .clr_a_idx (head_q),
    .clr_b_en  (commit_ok),
    .clr_b_idx (tail_q),
    .rd_idx    (tail_q),
    .rd_done   (tail_done)
  );

  assign alloc_seq_num   = head_q;
  assign oldest_seq_num  = tail_q;
  assign oldest_complete = (count_q != '0) && tail_done;
  assign in_flight       = count_q;
  assign empty           = (count_q == '0);
  assign err             = err_q;

  // Line trace: grant marker, head, tail, count, error marker.
  function automatic string trace();
    return $sformatf("%s%0d|%0d#%0d%s",
                     alloc_fire ? "+" : ".", head_q, tail_q, count_q,
                     err_q ? "!" : " ");
  endfunction

endmodule

// File: tb/tb_seq_num_alloc.sv
module tb_seq_num_alloc;

  localparam int unsigned NB    = 3;
  localparam int          DEPTH = 8;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          alloc_val = 1'b0;
  logic          alloc_rdy;
  logic [NB-1:0] alloc_seq_num;
  logic          complete_val = 1'b0;
  logic [NB-1:0] complete_seq_num = '0;
  logic          commit_val = 1'b0;
  logic [NB-1:0] commit_seq_num = '0;
  logic          squash_val = 1'b0;
  logic [NB-1:0] squash_seq_num = '0;
  logic [NB-1:0] oldest_seq_num;
  logic          oldest_complete;
  logic [NB:0]   in_flight;
  logic          empty;
  logic          err;

  always #5 clk = ~clk;

  seq_num_alloc #(.p_seq_num_bits(NB)) dut (
    .clk              (clk),
    .rst              (rst),
    .alloc_val        (alloc_val),
    .alloc_rdy        (alloc_rdy),
    .alloc_seq_num    (alloc_seq_num),
    .complete_val     (complete_val),
    .complete_seq_num (complete_seq_num),
    .commit_val       (commit_val),
    .commit_seq_num   (commit_seq_num),
    .squash_val       (squash_val),
    .squash_seq_num   (squash_seq_num),
    .oldest_seq_num   (oldest_seq_num),
    .oldest_complete  (oldest_complete),
    .in_flight        (in_flight),
    .empty            (empty),
    .err              (err)
  );

  typedef struct {
    bit rdy;
    bit grant;
    int num;
    int inflt;
    int oldest;
    bit ocomp;
    bit emp;
    bit err;
  } exp_t;

  exp_t exp_q[$];

  // Reference model: ordered list of live numbers, oldest first.
  int m_q[$];
  bit m_done[DEPTH];
  int m_next = 0;
  bit m_err  = 1'b0;

  int checks = 0;
  int errors = 0;

  function automatic bit m_has(input int s);
    foreach (m_q[i]) if (m_q[i] == s) return 1'b1;
    return 1'b0;
  endfunction

  task automatic chk(input string name, input int act, input int req);
    checks++;
    if (act != req) begin
      errors++;
      $display("FAIL %s actual %0d expected %0d at %0t", name, act, req, $time);
    end
  endtask

  // One clock of stimulus; pushes what the DUT must show during this cycle,
  // then advances the model to the state after the coming edge.
  task automatic cycle(input bit r, input bit av,
                       input bit cv, input int cn,
                       input bit mv, input int mn,
                       input bit qv, input int qn);
    exp_t e;
    bit   comp_ok, com_ok, sq_ok;
    @(negedge clk);
    rst              = r;
    alloc_val        = av;
    complete_val     = cv;
    complete_seq_num = cn[NB-1:0];
    commit_val       = mv;
    commit_seq_num   = mn[NB-1:0];
    squash_val       = qv;
    squash_seq_num   = qn[NB-1:0];
    if (!r) begin
      m_q.delete();
      m_next = 0;
      m_err  = 1'b0;
      foreach (m_done[i]) m_done[i] = 1'b0;
    end
    e.rdy    = r && (m_q.size() < DEPTH) && !qv;
    e.grant  = av && e.rdy;
    e.num    = m_next;
    e.inflt  = m_q.size();
    e.oldest = (m_q.size() != 0) ? m_q[0] : m_next;
    e.ocomp  = (m_q.size() != 0) && m_done[m_q[0]];
    e.emp    = (m_q.size() == 0);
    e.err    = m_err;
    exp_q.push_back(e);
    if (r) begin
      comp_ok = cv && m_has(cn);
      com_ok  = mv && (m_q.size() != 0) && (m_q[0] == mn);
      sq_ok   = qv && m_has(qn);
      if ((cv && !comp_ok) || (mv && !com_ok) || (qv && !sq_ok)) m_err = 1'b1;
      if (comp_ok) m_done[cn] = 1'b1;
      if (com_ok) begin
        void'(m_q.pop_front());
        m_done[mn] = 1'b0;
      end
      if (sq_ok) begin
        while (m_q.size() != 0 && m_q[$] != qn) void'(m_q.pop_back());
        m_next = (qn + 1) % DEPTH;
      end
      if (e.grant) begin
        m_q.push_back(m_next);
        m_done[m_next] = 1'b0;
        m_next = (m_next + 1) % DEPTH;
      end
    end
  endtask

  task automatic idle();
    cycle(1, 0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    cycle(0, 1, 0, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 0, 0);
  endtask

  // Monitor: compares whatever the DUT presents against the queued record.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      #1;
      if (exp_q.size() == 0) begin
        if (alloc_val && alloc_rdy) begin
          checks++;
          errors++;
          $display("FAIL spurious_grant actual %0d expected none", alloc_seq_num);
        end
      end else begin
        e = exp_q.pop_front();
        chk("alloc_rdy", int'(alloc_rdy), int'(e.rdy));
        if (alloc_val && alloc_rdy) chk("alloc_seq_num", int'(alloc_seq_num), e.num);
        chk("in_flight", int'(in_flight), e.inflt);
        chk("oldest_seq_num", int'(oldest_seq_num), e.oldest);
        chk("oldest_complete", int'(oldest_complete), int'(e.ocomp));
        chk("empty", int'(empty), int'(e.emp));
        chk("err", int'(err), int'(e.err));
      end
    end
  end

  initial begin
    int cn, mn, qn;
    bit r, av, cv, mv, qv;

    // Fill: eight grants, ninth request stalls.
    do_reset();
    repeat (9) cycle(1, 1, 0, 0, 0, 0, 0, 0);
    // Commit at full with alloc pending: grant only on the following cycle.
    cycle(1, 1, 0, 0, 1, 0, 0, 0);
    cycle(1, 1, 0, 0, 0, 0, 0, 0);
    idle();

    // Out-of-order completion, in-order commit.
    do_reset();
    repeat (3) cycle(1, 1, 0, 0, 0, 0, 0, 0);
    cycle(1, 0, 1, 2, 0, 0, 0, 0);
    cycle(1, 0, 1, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 1, 0, 0, 0);
    cycle(1, 0, 1, 1, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 1, 1, 0, 0);
    cycle(1, 0, 0, 0, 1, 2, 0, 0);
    idle();

    // Squash rollback, then squash of the tail together with its commit.
    do_reset();
    repeat (6) cycle(1, 1, 0, 0, 0, 0, 0, 0);
    cycle(1, 1, 0, 0, 0, 0, 1, 2);
    idle();
    cycle(1, 0, 0, 0, 1, 0, 1, 0);
    cycle(1, 1, 0, 0, 0, 0, 0, 0);
    idle();

    // Protocol errors and reset clearing them.
    do_reset();
    repeat (3) cycle(1, 1, 0, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 1, 1, 0, 0);
    cycle(1, 0, 1, 6, 0, 0, 0, 0);
    cycle(1, 1, 1, 3, 0, 0, 0, 0);
    idle();
    do_reset();
    cycle(1, 1, 0, 0, 0, 0, 0, 0);
    idle();

    // Back-to-back alloc/commit pairs across the wrap.
    do_reset();
    cycle(1, 1, 0, 0, 0, 0, 0, 0);
    repeat (19) cycle(1, 1, 0, 0, 1, m_q[0], 0, 0);
    cycle(1, 0, 0, 0, 1, m_q[0], 0, 0);
    idle();

    // Randomised traffic, mostly legal, with occasional resets.
    do_reset();
    for (int i = 0; i < 2000; i++) begin
      r  = ($urandom_range(199) != 0);
      av = ($urandom_range(9) < 7);
      cv = ($urandom_range(9) < 4);
      mv = ($urandom_range(9) < 4);
      qv = ($urandom_range(29) == 0);
      cn = (m_q.size() != 0 && $urandom_range(39) != 0) ?
           m_q[$urandom_range(m_q.size() - 1)] : int'($urandom_range(DEPTH - 1));
      mn = (m_q.size() != 0 && $urandom_range(39) != 0) ?
           m_q[0] : int'($urandom_range(DEPTH - 1));
      qn = (m_q.size() != 0 && $urandom_range(19) != 0) ?
           m_q[$urandom_range(m_q.size() - 1)] : int'($urandom_range(DEPTH - 1));
      cycle(r, av, cv, cn, mv, mn, qv, qn);
    end

    @(negedge clk);
    alloc_val    = 1'b0;
    complete_val = 1'b0;
    commit_val   = 1'b0;
    squash_val   = 1'b0;
    rst          = 1'b1;
    @(negedge clk);
    #2;
    if (exp_q.size() != 0) begin
      checks++;
      errors++;
      $display("FAIL leftover_records actual %0d expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
